// File: rtl/arb_stream_mux_pkg.sv
// -----------------------------------------------------------------------------
// arb_stream_mux_pkg
// Shared helpers for the arbiter-driven stream multiplexer and other users of
// the round-robin/priority arbiter:
//   sel_width()  - width of a binary port index (never less than 1 bit)
//   slice_lsb()  - bit offset of port `port` inside a flattened
//                  PORTS*width data bus
// -----------------------------------------------------------------------------
package arb_stream_mux_pkg;

    // Smallest legal number of arbitrated ports.
    localparam int ARB_MIN_PORTS = 2;

    // Binary index width for `ports` requesters.
    function automatic int sel_width(input int ports);
        if (ports > 1) begin
            return $clog2(ports);
        end else begin
            return 1;
        end
    endfunction

    // Offset of the lane belonging to `port` in a flattened data bus.
    function automatic int slice_lsb(input int port, input int width);
        return port * width;
    endfunction

endpackage

// File: rtl/arb_stream_mux_chk.sv
// -----------------------------------------------------------------------------
// arb_stream_mux_chk
// Protocol checker for the arbiter side of arb_stream_mux:
//   - grant never has more than one bit set
//   - grant stays put while a packet is open (first beat accepted, last not)
// Ports mirror the arbiter-side signals of arb_stream_mux.
// -----------------------------------------------------------------------------
module arb_stream_mux_chk #(
    parameter int PORTS = 4
) (
    input logic             clk,
    input logic             rst,
    input logic [PORTS-1:0] grant,
    input logic [PORTS-1:0] s_valid,
    input logic [PORTS-1:0] s_ready,
    input logic [PORTS-1:0] s_last
);

    logic             r_open;
    logic [PORTS-1:0] w_fire;

    assign w_fire = s_valid & s_ready;

    // Tracks whether a packet has started but not finished.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_open <= 1'b0;
        end else if (|(w_fire & s_last)) begin
            r_open <= 1'b0;
        end else if (|w_fire) begin
            r_open <= 1'b1;
        end else begin
            r_open <= r_open;
        end
    end

    a_grant_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(grant))
        else $error("arb_stream_mux_chk: grant has more than one bit set");

    a_grant_held: assert property (@(posedge clk) disable iff (rst) r_open |-> $stable(grant))
        else $error("arb_stream_mux_chk: grant changed inside an open packet");

endmodule

// File: rtl/arb_stream_skid.sv
// -----------------------------------------------------------------------------
// arb_stream_skid
// Registered output stage with a main register and a one-entry temp register.
// The upstream ready is itself registered, so a beat can still arrive in the
// cycle after the sink stalls; that beat is parked in temp.
//   clk, rst  - clock, synchronous active-high reset
//   i_data    - beat payload (WIDTH bits)
//   i_valid   - beat present this cycle (already qualified by o_ready)
//   o_ready   - registered ready towards the input side
//   o_data    - registered output payload
//   o_valid   - registered output valid
//   i_ready   - downstream accept
// -----------------------------------------------------------------------------
module arb_stream_skid #(
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_valid,
    output logic             o_ready,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    input  logic             i_ready
);

    logic [WIDTH-1:0] r_main_data;
    logic             r_main_valid;
    logic [WIDTH-1:0] r_temp_data;
    logic             r_temp_valid;
    logic             r_ready_int;

    logic w_ready_int_early;
    logic w_main_valid_next;
    logic w_temp_valid_next;
    logic w_load_main_in;
    logic w_load_temp_in;
    logic w_load_main_temp;

    // Ready for next cycle: sink accepts, or nothing is parked and the main
    // register will not be holding an unaccepted beat.
    assign w_ready_int_early = i_ready | (~r_temp_valid & (~r_main_valid | ~i_valid));

    // Next-state selection: input to main, input to temp, or temp to main.
    always_comb begin
        w_main_valid_next = r_main_valid;
        w_temp_valid_next = r_temp_valid;
        w_load_main_in    = 1'b0;
        w_load_temp_in    = 1'b0;
        w_load_main_temp  = 1'b0;
        if (r_ready_int) begin
            if (i_ready || !r_main_valid) begin
                w_main_valid_next = i_valid;
                w_load_main_in    = i_valid;
            end else begin
                w_temp_valid_next = i_valid;
                w_load_temp_in    = i_valid;
            end
        end else if (i_ready) begin
            w_main_valid_next = r_temp_valid;
            w_temp_valid_next = 1'b0;
            w_load_main_temp  = 1'b1;
        end else begin
            // Stalled with the input blocked: everything holds.
            w_load_main_temp  = 1'b0;
        end
    end

    // Main/temp/ready state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_main_data  <= {WIDTH{1'b0}};
            r_main_valid <= 1'b0;
            r_temp_data  <= {WIDTH{1'b0}};
            r_temp_valid <= 1'b0;
            r_ready_int  <= 1'b0;
        end else begin
            r_ready_int  <= w_ready_int_early;
            r_main_valid <= w_main_valid_next;
            r_temp_valid <= w_temp_valid_next;
            if (w_load_main_in) begin
                r_main_data <= i_data;
            end else if (w_load_main_temp) begin
                r_main_data <= r_temp_data;
            end else begin
                r_main_data <= r_main_data;
            end
            if (w_load_temp_in) begin
                r_temp_data <= i_data;
            end else begin
                r_temp_data <= r_temp_data;
            end
        end
    end

    assign o_ready = r_ready_int;
    assign o_data  = r_main_data;
    assign o_valid = r_main_valid;

endmodule

// File: rtl/arb_stream_mux.sv
// -----------------------------------------------------------------------------
// arb_stream_mux
// Packet multiplexer wrapped around an external block-on-acknowledge arbiter.
// Requests come from the per-port valids; the arbiter's grant is held for a
// whole packet and released by an acknowledge pulse on the last beat.
//   clk, rst        - clock, synchronous active-high reset
//   s_data/valid/last/ready - PORTS input streams (data flattened, port i at
//                     [i*DATA_WIDTH +: DATA_WIDTH])
//   request, acknowledge    - to the arbiter
//   grant, grant_valid, grant_encoded - from the arbiter
//   m_data/valid/last/ready - single registered output stream
// -----------------------------------------------------------------------------
module arb_stream_mux
    import arb_stream_mux_pkg::*;
#(
    parameter int PORTS      = 4,
    parameter int DATA_WIDTH = 8,
    parameter int SEL_WIDTH  = sel_width(PORTS)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [PORTS*DATA_WIDTH-1:0] s_data,
    input  logic [PORTS-1:0]            s_valid,
    input  logic [PORTS-1:0]            s_last,
    output logic [PORTS-1:0]            s_ready,
    output logic [PORTS-1:0]            request,
    output logic [PORTS-1:0]            acknowledge,
    input  logic [PORTS-1:0]            grant,
    input  logic                        grant_valid,
    input  logic [SEL_WIDTH-1:0]        grant_encoded,
    output logic [DATA_WIDTH-1:0]       m_data,
    output logic                        m_valid,
    output logic                        m_last,
    input  logic                        m_ready
);

    logic [PORTS-1:0]      w_in_fire;
    logic [DATA_WIDTH-1:0] w_in_data;
    logic                  w_in_last;
    logic                  w_in_valid;
    logic                  w_ready_int;

    // Only the granted port may transfer, and only when the skid has room.
    assign s_ready     = (grant_valid && w_ready_int && !rst) ? grant : {PORTS{1'b0}};
    assign w_in_fire   = s_valid & s_ready;
    assign acknowledge = w_in_fire & s_last;
    // Hiding the acknowledging port keeps the arbiter from re-granting it
    // before its next packet is actually presented.
    assign request     = s_valid & ~acknowledge & {PORTS{~rst}};
    assign w_in_valid  = |w_in_fire;

    // Lane select by the binary grant index (AND-OR mux, one lane matches).
    always_comb begin
        w_in_data = {DATA_WIDTH{1'b0}};
        w_in_last = 1'b0;
        for (int i = 0; i < PORTS; i++) begin
            w_in_data = w_in_data
                      | (s_data[slice_lsb(i, DATA_WIDTH) +: DATA_WIDTH]
                         & {DATA_WIDTH{grant_encoded == SEL_WIDTH'(i)}});
            w_in_last = w_in_last | (s_last[i] & (grant_encoded == SEL_WIDTH'(i)));
        end
    end

    arb_stream_skid #(
        .WIDTH (DATA_WIDTH + 1)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .i_data  ({w_in_last, w_in_data}),
        .i_valid (w_in_valid),
        .o_ready (w_ready_int),
        .o_data  ({m_last, m_data}),
        .o_valid (m_valid),
        .i_ready (m_ready)
    );

endmodule

// File: tb/tb_arb_stream_mux.sv
// -----------------------------------------------------------------------------
// tb_arb_stream_mux
// Bench for arb_stream_mux with a behavioural round-robin block-on-acknowledge
// arbiter. Expected output is a packet-level scoreboard: whenever the arbiter
// grants a port, that port's next whole packet is appended to the expected
// stream, which the output must reproduce beat for beat.
// -----------------------------------------------------------------------------
module tb_arb_stream_mux;

    localparam int PORTS = 4;
    localparam int DW    = 8;
    localparam int SW    = 2;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [PORTS*DW-1:0]   s_data;
    logic [PORTS-1:0]      s_valid, s_last, s_ready, request, acknowledge, grant;
    logic                  grant_valid;
    logic [SW-1:0]         grant_encoded;
    logic [DW-1:0]         m_data;
    logic                  m_valid, m_last, m_ready;

    always #5 clk = ~clk;

    arb_stream_mux #(.PORTS(PORTS), .DATA_WIDTH(DW), .SEL_WIDTH(SW)) dut (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
        .s_ready(s_ready), .request(request), .acknowledge(acknowledge),
        .grant(grant), .grant_valid(grant_valid), .grant_encoded(grant_encoded),
        .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready)
    );

    arb_stream_mux_chk #(.PORTS(PORTS)) u_chk (
        .clk(clk), .rst(rst), .grant(grant), .s_valid(s_valid),
        .s_ready(s_ready), .s_last(s_last)
    );

    // ---------------- bookkeeping ----------------
    int n_vec = 0;
    int n_err = 0;

    // Single comparison point for the whole bench.
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- environment state ----------------
    logic [DW:0] port_q [PORTS][$];   // {last, data} beats waiting per port
    logic [DW:0] exp_q [$];           // expected output beats in order
    logic        arb_gv;
    int          arb_idx, arb_last;
    int          valid_pct, mr_mode;  // mr_mode: 0 ready, 1 stalled, 2 toggle, 3 random
    logic        mr_tog;
    int          cyc, first_fire, first_out, last_out;
    int          acks [PORTS];
    int          fires [PORTS];
    logic        hold;
    logic [DW+1:0] held;
    logic [PORTS-1:0] samp_req, samp_ack, samp_fire;
    logic        samp_rst;

    function automatic logic busy();
        logic b = (exp_q.size() != 0) || m_valid;
        for (int i = 0; i < PORTS; i++) b = b || (port_q[i].size() != 0);
        return b;
    endfunction

    task automatic add_beat(input int p, input logic [DW-1:0] d, input logic l);
        port_q[p].push_back({l, d});
    endtask

    task automatic add_pkt(input int p, input int len);
        for (int j = 0; j < len; j++) add_beat(p, DW'($urandom), (j == len - 1));
    endtask

    task automatic start_test(input int vpct, input int mode);
        valid_pct = vpct; mr_mode = mode;
        first_fire = -1; first_out = -1; last_out = -1;
        for (int i = 0; i < PORTS; i++) begin acks[i] = 0; fires[i] = 0; end
    endtask

    // Drive all DUT inputs from the environment state.
    task automatic drive();
        for (int i = 0; i < PORTS; i++) begin
            if (port_q[i].size() != 0 && $urandom_range(99) < valid_pct) begin
                s_valid[i] = 1'b1;
                s_data[i*DW +: DW] = port_q[i][0][DW-1:0];
                s_last[i] = port_q[i][0][DW];
            end else begin
                s_valid[i] = 1'b0;
                s_data[i*DW +: DW] = DW'($urandom);
                s_last[i] = 1'($urandom);
            end
        end
        grant_valid   = arb_gv;
        grant         = arb_gv ? PORTS'(1 << arb_idx) : '0;
        grant_encoded = SW'(arb_idx);
        case (mr_mode)
            0: m_ready = 1'b1;
            1: m_ready = 1'b0;
            2: m_ready = mr_tog;
            default: m_ready = 1'($urandom_range(1));
        endcase
    endtask

    // Round robin from the port after the last one served.
    task automatic arbitrate();
        if (!arb_gv || samp_ack[arb_idx]) begin
            arb_gv = 1'b0;
            for (int k = 1; k <= PORTS; k++) begin
                int p = (arb_last + k) % PORTS;
                if (!arb_gv && samp_req[p]) begin
                    arb_gv = 1'b1; arb_idx = p; arb_last = p;
                    for (int j = 0; j < port_q[p].size(); j++) begin
                        exp_q.push_back(port_q[p][j]);
                        if (port_q[p][j][DW]) break;
                    end
                end
            end
        end
    endtask

    // One clock: observe at negedge, advance the environment after posedge.
    task automatic cycle();
        logic [PORTS-1:0] exp_ack;
        @(negedge clk);
        cyc++;
        samp_rst  = rst;
        samp_fire = s_valid & s_ready;
        samp_req  = request;
        samp_ack  = acknowledge;
        if (rst) begin
            check_eq("rst_comb_outputs", {s_ready, request, acknowledge}, 32'd0);
        end else begin
            exp_ack = '0;
            for (int i = 0; i < PORTS; i++)
                if (samp_fire[i]) exp_ack[i] = port_q[i][0][DW];
            check_eq("s_ready_ungranted", s_ready & ~grant, 32'd0);
            check_eq("acknowledge", acknowledge, exp_ack);
            check_eq("request", request, s_valid & ~exp_ack);
            if (hold) check_eq("output_hold", {m_valid, m_last, m_data}, held);
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) check_eq("unexpected_beat", {m_last, m_data}, 32'hFFFF_FFFF);
                else check_eq("out_beat", {m_last, m_data}, exp_q.pop_front());
                if (first_out < 0) first_out = cyc;
                last_out = cyc;
            end
            for (int i = 0; i < PORTS; i++) begin
                if (samp_fire[i]) begin
                    fires[i]++;
                    if (first_fire < 0) first_fire = cyc;
                end
                if (acknowledge[i]) acks[i]++;
            end
            hold = m_valid & ~m_ready;
            held = {m_valid, m_last, m_data};
        end
        @(posedge clk);
        #1;
        if (samp_rst) begin
            arb_gv = 1'b0; arb_idx = 0; arb_last = PORTS - 1;
            for (int i = 0; i < PORTS; i++) port_q[i].delete();
            exp_q.delete();
            hold = 1'b0;
        end else begin
            for (int i = 0; i < PORTS; i++)
                if (samp_fire[i]) void'(port_q[i].pop_front());
            arbitrate();
        end
        mr_tog = ~mr_tog;
        drive();
    endtask

    task automatic run_until_idle(input int budget);
        int n = 0;
        while (busy() && n < budget) begin cycle(); n++; end
        check_eq("drain_idle", busy(), 32'd0);
        for (int k = 0; k < 3; k++) cycle();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int pkts;
        int a_tot;
        rst = 1'b1; arb_gv = 1'b0; arb_idx = 0; arb_last = PORTS - 1;
        mr_tog = 1'b1; hold = 1'b0; cyc = 0;
        s_valid = '0; s_last = '0; s_data = '0;
        start_test(100, 0);
        drive();
        for (int k = 0; k < 3; k++) cycle();
        rst = 1'b0;
        #1;
        check_eq("reset_m_state", {m_valid, m_last, m_data}, 32'd0);

        // Single 3-beat packet on port 0.
        start_test(100, 0);
        add_beat(0, 8'h11, 1'b0); add_beat(0, 8'h22, 1'b0); add_beat(0, 8'h33, 1'b1);
        run_until_idle(50);
        check_eq("t1_latency", first_out - first_fire, 32'd1);
        check_eq("t1_span", last_out - first_out, 32'd2);
        check_eq("t1_acks", acks[0], 32'd1);

        // Ports 1 and 2 together, two beats each.
        start_test(100, 0);
        add_pkt(1, 2); add_pkt(2, 2);
        run_until_idle(50);
        check_eq("t2_no_idle", last_out - first_out, 32'd3);
        check_eq("t2_acks", acks[1] + acks[2], 32'd2);

        // Port 3, 4 beats, sink stalled from the start.
        start_test(100, 1);
        add_beat(3, 8'hA0, 1'b0); add_beat(3, 8'hA1, 1'b0);
        add_beat(3, 8'hA2, 1'b0); add_beat(3, 8'hA3, 1'b1);
        for (int k = 0; k < 10; k++) cycle();
        #1;
        check_eq("t3_absorbed", fires[3], 32'd2);
        check_eq("t3_s_ready_low", s_ready[3], 32'd0);
        check_eq("t3_held_beat0", {m_valid, m_data}, {1'b1, 8'hA0});
        mr_mode = 0;
        run_until_idle(50);
        check_eq("t3_acks", acks[3], 32'd1);

        // 6-beat packet with m_ready toggling.
        start_test(100, 2);
        add_pkt(0, 6);
        run_until_idle(100);
        check_eq("t4_acks", acks[0], 32'd1);

        // Back-to-back single-beat packets on port 0.
        start_test(100, 0);
        add_beat(0, 8'h5A, 1'b1); add_beat(0, 8'hC3, 1'b1);
        run_until_idle(50);
        check_eq("t5_acks", acks[0], 32'd2);

        // Reset in the middle of a packet on port 2.
        start_test(100, 0);
        add_pkt(2, 4);
        for (int k = 0; k < 20 && fires[2] < 2; k++) cycle();
        check_eq("t6_two_fired", fires[2], 32'd2);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        #1;
        check_eq("t6_after_rst", {m_valid, s_ready, request}, 32'd0);
        start_test(100, 0);
        add_pkt(1, 3);
        run_until_idle(50);
        check_eq("t6_fresh_acks", acks[1], 32'd1);

        // Randomized traffic, two rounds with different sink behaviour.
        for (int r = 0; r < 2; r++) begin
            start_test(70, (r == 0) ? 3 : 2);
            pkts = 0;
            for (int k = 0; k < 40; k++) begin
                add_pkt($urandom_range(PORTS - 1), $urandom_range(1, 5));
                pkts++;
            end
            run_until_idle(4000);
            a_tot = 0;
            for (int i = 0; i < PORTS; i++) a_tot += acks[i];
            check_eq("rand_acks", a_tot, pkts);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
